div9_hw_unit: RTL

Sequential divide-by-constant unit that sits directly downstream of the `div9_toHW` Avalon PIO output port. It consumes the 8-bit value software writes to that port. It computes the quotient and remainder by restoring long division, one bit per clock. It presents the registered results, with busy/valid status, for the return-path PIO (`div9_fromHW`) to read.

---
 rtl/div9_hw_unit.sv | 99 +++++++++
 1 files changed

// File: rtl/div9_hw_unit.sv
// Divide-by-constant unit fed by the div9_toHW PIO: restoring long division, one quotient bit
// per clock, with registered quotient/remainder and busy/valid/done status for div9_fromHW.
module div9_hw_unit #(
   parameter int unsigned DIVISOR = 9
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [7:0] din_i,
   output logic [7:0] quotient_o,
   output logic [7:0] remainder_o,
   output logic       busy_o,
   output logic       valid_o,
   output logic       done_o
);

   localparam logic [8:0] Div = 9'(DIVISOR);

   typedef enum logic {StIdle, StCalc} state_e;

   state_e     state_q;
   logic [7:0] last_din_q;
   logic [7:0] dvd_q;
   logic [7:0] acc_q;
   logic [7:0] qsh_q;
   logic [2:0] cnt_q;
   logic [7:0] quotient_q;
   logic [7:0] remainder_q;
   logic       busy_q;
   logic       valid_q;
   logic       done_q;

   logic [8:0] trial;
   logic       ge;
   logic [7:0] acc_d;
   logic [7:0] qsh_d;

   // Partial remainder is always < DIVISOR, so 8 stored bits suffice; the trial keeps the ninth.
   always_comb begin
      trial = {acc_q, dvd_q[7]};
      ge    = (trial >= Div);
      acc_d = ge ? 8'(trial - Div) : trial[7:0];
      qsh_d = {qsh_q[6:0], ge};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= StIdle;
         last_din_q  <= 8'd0;
         dvd_q       <= 8'd0;
         acc_q       <= 8'd0;
         qsh_q       <= 8'd0;
         cnt_q       <= 3'd0;
         quotient_q  <= 8'd0;
         remainder_q <= 8'd0;
         busy_q      <= 1'b0;
         valid_q     <= 1'b1;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               // An identical rewrite leaves the already-valid result alone.
               if (din_i != last_din_q) begin
                  dvd_q      <= din_i;
                  last_din_q <= din_i;
                  acc_q      <= 8'd0;
                  qsh_q      <= 8'd0;
                  cnt_q      <= 3'd7;
                  busy_q     <= 1'b1;
                  valid_q    <= 1'b0;
                  state_q    <= StCalc;
               end
            end
            StCalc: begin
               dvd_q <= {dvd_q[6:0], 1'b0};
               acc_q <= acc_d;
               qsh_q <= qsh_d;
               if (cnt_q == 3'd0) begin
                  quotient_q  <= qsh_d;
                  remainder_q <= acc_d;
                  busy_q      <= 1'b0;
                  valid_q     <= 1'b1;
                  done_q      <= 1'b1;
                  state_q     <= StIdle;
               end else begin
                  cnt_q <= cnt_q - 3'd1;
               end
            end
         endcase
      end
   end

   assign quotient_o  = quotient_q;
   assign remainder_o = remainder_q;
   assign busy_o      = busy_q;
   assign valid_o     = valid_q;
   assign done_o      = done_q;

endmodule
